neuron_sampler: RTL

NEURON_SAMPLER -- requirements
Module: neuron_sampler

---
 rtl/config.v | 6 +
 rtl/neuron_sampler.sv | 112 +++++++++++
 2 files changed

// File: rtl/config.v
// Shared configuration for the sampling datapath.
// BITN: width of the random word and the probability word.
`ifndef CONFIG_V
`define CONFIG_V
`define BITN 8
`endif

// File: rtl/neuron_sampler.sv
// neuron_sampler
// Turns a stream of per-unit activation probabilities into binary unit vectors.
// Each accepted probability produces one sample bit. The bit comes from a random
// draw (rnd < prob) or from a deterministic threshold (prob >= 0.5) when meanField
// is set. NUNITS bits are packed into a vector, with a count of its ones. The
// vector is held until downstream takes it.
//
// Ports
//   clk        : clock; all state updates on its rising edge
//   reset      : synchronous, active-high reset
//   rnd        : uniform random word, changes every cycle
//   prob       : unsigned probability, 2^BITN represents 1.0
//   probValid  : prob is valid this cycle
//   probReady  : block accepts prob this cycle (COLLECT state)
//   meanField  : 1 selects the deterministic threshold
//   flush      : discard the partial or pending vector
//   vec        : sampled unit states, unit 0 at the LSB
//   onesCount  : number of ones in vec
//   vecValid   : vec and onesCount are valid (HOLD state)
//   vecReady   : downstream accepts vec
`include "config.v"

module neuron_sampler #(
    parameter int unsigned NUNITS = 16,
    parameter int unsigned CNTW   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [`BITN-1:0]  rnd,
    input  logic [`BITN-1:0]  prob,
    input  logic              probValid,
    output logic              probReady,
    input  logic              meanField,
    input  logic              flush,
    output logic [NUNITS-1:0] vec,
    output logic [CNTW-1:0]   onesCount,
    output logic              vecValid,
    input  logic              vecReady
);

    typedef enum logic [0:0] {
        StCollect = 1'b0,
        StHold    = 1'b1
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CNTW-1:0]   r_idx;
    logic [CNTW-1:0]   w_idx_next;
    logic [NUNITS-1:0] r_vec;
    logic [NUNITS-1:0] w_vec_next;
    logic [CNTW-1:0]   r_ones;
    logic [CNTW-1:0]   w_ones_next;
    logic              w_bit;

    // Sample bit; the MSB of prob is exactly the prob >= 0.5 test.
    assign w_bit = meanField ? prob[`BITN-1] : (rnd < prob);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_vec_next   = r_vec;
        w_ones_next  = r_ones;

        if (flush) begin
            // Flush beats both an accept and a vector handshake.
            w_state_next = StCollect;
            w_idx_next   = '0;
            w_vec_next   = '0;
            w_ones_next  = '0;
        end else if (r_state == StHold) begin
            if (vecReady) begin
                w_state_next = StCollect;
                w_vec_next   = '0;
                w_ones_next  = '0;
            end
        end else if (probValid) begin
            for (int i = 0; i < NUNITS; i++) begin
                if (r_idx == CNTW'(i)) begin
                    w_vec_next[i] = w_bit;
                end
            end
            w_ones_next = r_ones + CNTW'(w_bit);
            if (r_idx == CNTW'(NUNITS - 1)) begin
                w_idx_next   = '0;
                w_state_next = StHold;
            end else begin
                w_idx_next = r_idx + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StCollect;
            r_idx   <= '0;
            r_vec   <= '0;
            r_ones  <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_vec   <= w_vec_next;
            r_ones  <= w_ones_next;
        end
    end

    assign probReady = (r_state == StCollect);
    assign vecValid  = (r_state == StHold);
    assign vec       = r_vec;
    assign onesCount = r_ones;

endmodule
